// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sharing controller: FSM states,
// LFSR geometry and the next-value / seed-fix helpers.
package lfsr_pkg;

  localparam int LFSR_WIDTH = 8;
  localparam logic [LFSR_WIDTH-1:0] LFSR_RESET_VAL = 8'h01;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    LOAD  = 2'd1,
    WARM  = 2'd2
  } state_t;

  // One Fibonacci step: feedback is the parity of bit 0 and the two taps,
  // which the caller folds into tap_mask.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(
    input logic [LFSR_WIDTH-1:0] cur,
    input logic [LFSR_WIDTH-1:0] tap_mask
  );
    return {^(cur & tap_mask), cur[LFSR_WIDTH-1:1]};
  endfunction

  // An all-zero state would lock the LFSR up, so it becomes the reset value.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_seed_fix(
    input logic [LFSR_WIDTH-1:0] seed_val
  );
    return (seed_val == 8'h00) ? LFSR_RESET_VAL : seed_val;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// 8-bit two-tap Fibonacci LFSR register. A load takes priority over a
// step; with neither request the register holds.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int TAP_ONE = 2,
  parameter int TAP_TWO = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  step,
  input  logic                  load,
  input  logic [LFSR_WIDTH-1:0] load_val,
  output logic [LFSR_WIDTH-1:0] value
);

  localparam logic [LFSR_WIDTH-1:0] TAP_MASK =
    8'h01 | (8'h01 << TAP_ONE) | (8'h01 << TAP_TWO);

  logic [LFSR_WIDTH-1:0] lfsr_r;

  // LFSR state: seed load (zero substituted), else step, else hold
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_r <= LFSR_RESET_VAL;
    end else if (load) begin
      lfsr_r <= lfsr_seed_fix(load_val);
    end else if (step) begin
      lfsr_r <= lfsr_next(lfsr_r, TAP_MASK);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  assign value = lfsr_r;

endmodule

// File: rtl/lfsr_share_ctrl.sv
// Shares one LFSR between NUM_REQ requesters with round-robin grants,
// one random byte per grant, plus seed loading and a warm-up run.
module lfsr_share_ctrl
  import lfsr_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int TAP_ONE       = 2,
  parameter int TAP_TWO       = 4,
  parameter int WARMUP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  seed_valid,
  input  logic [LFSR_WIDTH-1:0] seed,
  output logic                  seed_ready,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  rnd_valid,
  output logic [LFSR_WIDTH-1:0] rnd_data,
  output logic                  busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int SUM_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [SUM_W-1:0] NUM_REQ_W = SUM_W'(NUM_REQ);
  localparam logic [7:0] WARM_INIT =
    (WARMUP_CYCLES > 0) ? 8'(WARMUP_CYCLES - 1) : 8'd0;

  state_t                state_r;
  state_t                next_state_s;
  logic [PTR_W-1:0]      rr_ptr_r;
  logic [7:0]            warm_cnt_r;
  logic [NUM_REQ-1:0]    gnt_r;
  logic                  rnd_valid_r;
  logic [LFSR_WIDTH-1:0] rnd_data_r;
  logic                  seed_ready_r;
  logic                  busy_r;

  logic [NUM_REQ-1:0]    eligible_s;
  logic [PTR_W-1:0]      winner_s;
  logic                  found_s;
  logic [NUM_REQ-1:0]    gnt_next_s;
  logic [PTR_W-1:0]      ptr_next_s;
  logic                  grant_s;
  logic                  lfsr_step_s;
  logic                  lfsr_load_s;
  logic [LFSR_WIDTH-1:0] lfsr_value_s;

  lfsr_core #(
    .TAP_ONE (TAP_ONE),
    .TAP_TWO (TAP_TWO)
  ) u_lfsr_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .step     (lfsr_step_s),
    .load     (lfsr_load_s),
    .load_val (seed),
    .value    (lfsr_value_s)
  );

  // Round-robin search: first eligible requester at or after rr_ptr, wrapping.
  // A requester whose grant is showing this cycle is skipped so a held req
  // is not granted twice in a row.
  always_comb begin
    logic [SUM_W-1:0] sum_v;
    eligible_s = req & ~gnt_r;
    winner_s   = {PTR_W{1'b0}};
    found_s    = 1'b0;
    sum_v      = {SUM_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_v = {1'b0, rr_ptr_r} + SUM_W'(i);
      if (sum_v >= NUM_REQ_W) begin
        sum_v = sum_v - NUM_REQ_W;
      end else begin
        sum_v = sum_v;
      end
      if (!found_s && eligible_s[sum_v[PTR_W-1:0]]) begin
        found_s  = 1'b1;
        winner_s = sum_v[PTR_W-1:0];
      end else begin
        found_s  = found_s;
      end
    end
    gnt_next_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
    ptr_next_s = (winner_s == LAST_IDX) ? {PTR_W{1'b0}} : winner_s + PTR_W'(1);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= SERVE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next state: seed wins in SERVE; LOAD lasts one cycle; WARM counts down
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      SERVE: begin
        if (seed_valid) begin
          next_state_s = LOAD;
        end else begin
          next_state_s = SERVE;
        end
      end
      LOAD: begin
        if (WARMUP_CYCLES == 0) begin
          next_state_s = SERVE;
        end else begin
          next_state_s = WARM;
        end
      end
      WARM: begin
        if (warm_cnt_r == 8'd0) begin
          next_state_s = SERVE;
        end else begin
          next_state_s = WARM;
        end
      end
      default: next_state_s = SERVE;
    endcase
  end

  // FSM outputs: grant/step/load strobes derived from state and inputs
  always_comb begin
    grant_s     = 1'b0;
    lfsr_step_s = 1'b0;
    lfsr_load_s = 1'b0;
    case (state_r)
      SERVE: begin
        if (seed_valid) begin
          lfsr_load_s = 1'b1;
        end else if (found_s) begin
          grant_s     = 1'b1;
          lfsr_step_s = 1'b1;
        end else begin
          grant_s     = 1'b0;
        end
      end
      LOAD: begin
        lfsr_step_s = 1'b0;
      end
      WARM: begin
        lfsr_step_s = 1'b1;
      end
      default: begin
        grant_s = 1'b0;
      end
    endcase
  end

  // Warm-up counter: preset in LOAD, decremented each WARM cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt_r <= 8'd0;
    end else if (state_r == LOAD) begin
      warm_cnt_r <= WARM_INIT;
    end else if ((state_r == WARM) && (warm_cnt_r != 8'd0)) begin
      warm_cnt_r <= warm_cnt_r - 8'd1;
    end else begin
      warm_cnt_r <= warm_cnt_r;
    end
  end

  // Grant/data registers: capture the pre-step LFSR value and advance rr_ptr
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_r       <= {NUM_REQ{1'b0}};
      rnd_valid_r <= 1'b0;
      rnd_data_r  <= 8'h00;
      rr_ptr_r    <= {PTR_W{1'b0}};
    end else if (grant_s) begin
      gnt_r       <= gnt_next_s;
      rnd_valid_r <= 1'b1;
      rnd_data_r  <= lfsr_value_s;
      rr_ptr_r    <= ptr_next_s;
    end else begin
      gnt_r       <= {NUM_REQ{1'b0}};
      rnd_valid_r <= 1'b0;
      rnd_data_r  <= rnd_data_r;
      rr_ptr_r    <= rr_ptr_r;
    end
  end

  // Status flags registered from the next state so they track state_r exactly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seed_ready_r <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      seed_ready_r <= (next_state_s == SERVE);
      busy_r       <= (next_state_s != SERVE);
    end
  end

  assign gnt        = gnt_r;
  assign rnd_valid  = rnd_valid_r;
  assign rnd_data   = rnd_data_r;
  assign seed_ready = seed_ready_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Self-checking bench for lfsr_share_ctrl: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_lfsr_share_ctrl;

  localparam int NREQ = 4;
  localparam int T1   = 2;
  localparam int T2   = 4;
  localparam int WARM = 2;

  logic       clk;
  logic       reset_n;
  logic       seed_valid;
  logic [7:0] seed;
  logic       seed_ready;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       rnd_valid;
  logic [7:0] rnd_data;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model: busy countdown instead of explicit states
  int          m_busy;
  logic [7:0]  m_lfsr;
  logic [7:0]  m_data;
  logic [3:0]  m_gnt;
  int          m_ptr;
  logic        m_acc;

  lfsr_share_ctrl #(
    .NUM_REQ       (NREQ),
    .TAP_ONE       (T1),
    .TAP_TWO       (T2),
    .WARMUP_CYCLES (WARM)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .seed_valid (seed_valid),
    .seed       (seed),
    .seed_ready (seed_ready),
    .req        (req),
    .gnt        (gnt),
    .rnd_valid  (rnd_valid),
    .rnd_data   (rnd_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_step(input logic [7:0] v);
    int fb;
    fb = ((v >> 0) & 1) ^ ((v >> T1) & 1) ^ ((v >> T2) & 1);
    return (v >> 1) | (fb != 0 ? 8'h80 : 8'h00);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_lfsr = 8'h01; m_data = 8'h00; m_gnt = 4'b0000; m_ptr = 0; m_acc = 1'b0;
  endtask

  task automatic model_update(input logic sv, input logic [7:0] sd, input logic [3:0] rq);
    logic [3:0] elig;
    int w;
    m_acc = 1'b0;
    if (m_busy == 0) begin
      if (sv) begin
        m_lfsr = (sd == 8'h00) ? 8'h01 : sd;
        m_busy = 1 + WARM;
        m_gnt  = 4'b0000;
        m_acc  = 1'b1;
      end else begin
        elig = rq & ~m_gnt;
        w = -1;
        for (int i = 0; i < NREQ; i++)
          if (w < 0 && elig[(m_ptr + i) % NREQ]) w = (m_ptr + i) % NREQ;
        if (w >= 0) begin
          m_gnt  = 4'b0001 << w;
          m_data = m_lfsr;
          m_lfsr = ref_step(m_lfsr);
          m_ptr  = (w + 1) % NREQ;
        end else begin
          m_gnt = 4'b0000;
        end
      end
    end else begin
      if (m_busy != 1 + WARM) m_lfsr = ref_step(m_lfsr);
      m_busy = m_busy - 1;
      m_gnt  = 4'b0000;
    end
  endtask

  task automatic tick(input logic sv, input logic [7:0] sd, input logic [3:0] rq);
    seed_valid = sv; seed = sd; req = rq;
    @(posedge clk);
    model_update(sv, sd, rq);
    #1;
  endtask

  task automatic apply_reset();
    seed_valid = 1'b0; seed = 8'h00; req = 4'b0000;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_tests++; if (rnd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rnd_valid: got %b want 0", rnd_valid); end
    n_tests++; if (rnd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rnd_data: got %h want 00", rnd_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (seed_ready !== 1'b1) begin n_fail++; $display("FAIL reset_seed_ready: got %b want 1", seed_ready); end
  endtask

  task automatic test_single_hold();
    logic [7:0] exp_d [6];
    logic [3:0] exp_g;
    exp_d[0] = 8'h01; exp_d[1] = 8'h80; exp_d[2] = 8'h40;
    exp_d[3] = 8'h20; exp_d[4] = 8'h10; exp_d[5] = 8'h88;
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      tick(1'b0, 8'h00, 4'b0001);
      exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      n_tests++;
      if (gnt !== exp_g) begin n_fail++; $display("FAIL hold_gnt[%0d]: got %b want %b", k, gnt, exp_g); end
      if (k % 2 == 0) begin
        n_tests++;
        if (rnd_data !== exp_d[k/2]) begin n_fail++; $display("FAIL hold_data[%0d]: got %h want %h", k/2, rnd_data, exp_d[k/2]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] rq;
    logic [3:0] exp_g [4];
    logic [7:0] exp_d [4];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000;
    exp_d[0] = 8'h01; exp_d[1] = 8'h80; exp_d[2] = 8'h40; exp_d[3] = 8'h20;
    apply_reset();
    rq = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 8'h00, rq);
      n_tests++;
      if (gnt !== exp_g[k]) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %b want %b", k, gnt, exp_g[k]); end
      n_tests++;
      if (rnd_data !== exp_d[k]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", k, rnd_data, exp_d[k]); end
      rq = rq & ~gnt;
    end
  endtask

  task automatic test_seed(input logic [7:0] sd, input logic [7:0] exp_first);
    int busy_cycles;
    int guard;
    apply_reset();
    tick(1'b1, sd, 4'b0000);
    n_tests++;
    if (seed_ready !== 1'b0) begin n_fail++; $display("FAIL seed_ready_low: got %b want 0", seed_ready); end
    busy_cycles = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 10) begin
      busy_cycles++;
      guard++;
      tick(1'b0, 8'h00, 4'b0000);
    end
    n_tests++;
    if (busy_cycles != 1 + WARM) begin n_fail++; $display("FAIL seed_busy_len: got %0d want %0d", busy_cycles, 1 + WARM); end
    tick(1'b0, 8'h00, 4'b0001);
    n_tests++;
    if (gnt !== 4'b0001 || rnd_data !== exp_first) begin
      n_fail++; $display("FAIL seed_first_data: got gnt %b data %h want gnt 0001 data %h", gnt, rnd_data, exp_first);
    end
  endtask

  task automatic test_seed_vs_req();
    int guard;
    apply_reset();
    tick(1'b0, 8'h00, 4'b0010);
    tick(1'b0, 8'h00, 4'b0000);
    tick(1'b1, 8'hC3, 4'b0010);
    n_tests++;
    if (gnt !== 4'b0000 || busy !== 1'b1) begin
      n_fail++; $display("FAIL seedreq_same_cycle: got gnt %b busy %b want gnt 0000 busy 1", gnt, busy);
    end
    guard = 0;
    while (busy === 1'b1 && guard < 10) begin
      guard++;
      tick(1'b0, 8'h00, 4'b0010);
      n_tests++;
      if (gnt !== 4'b0000) begin n_fail++; $display("FAIL seedreq_busy_gnt: got %b want 0000", gnt); end
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL seedreq_timeout: busy got %b want 0", busy); end
    tick(1'b0, 8'h00, 4'b0110);
    n_tests++;
    if (gnt !== 4'b0100) begin n_fail++; $display("FAIL seedreq_ptr: got %b want 0100", gnt); end
    tick(1'b0, 8'h00, 4'b0010);
    n_tests++;
    if (gnt !== 4'b0010) begin n_fail++; $display("FAIL seedreq_held: got %b want 0010", gnt); end
  endtask

  task automatic test_reset_mid_warm();
    apply_reset();
    tick(1'b0, 8'h00, 4'b0001);
    tick(1'b1, 8'h5A, 4'b0000);
    tick(1'b0, 8'h00, 4'b0000);
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || seed_ready !== 1'b1 || rnd_data !== 8'h00) begin
      n_fail++; $display("FAIL midwarm_reset: got gnt %b busy %b ready %b data %h want 0000 0 1 00", gnt, busy, seed_ready, rnd_data);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    tick(1'b0, 8'h00, 4'b1111);
    n_tests++;
    if (gnt !== 4'b0001 || rnd_data !== 8'h01) begin
      n_fail++; $display("FAIL midwarm_restart: got gnt %b data %h want 0001 01", gnt, rnd_data);
    end
  endtask

  task automatic test_random();
    logic       sv;
    logic [7:0] sd;
    logic [3:0] rq;
    sv = 1'b0; sd = 8'h00; rq = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      if (!sv && ($urandom % 25 == 0)) begin
        sv = 1'b1;
        sd = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
      end
      tick(sv, sd, rq);
      n_tests++;
      if (gnt !== m_gnt || rnd_valid !== (|m_gnt) || rnd_data !== m_data ||
          busy !== (m_busy != 0) || seed_ready !== (m_busy == 0)) begin
        n_fail++;
        $display("FAIL random[%0d]: got gnt %b v %b d %h busy %b rdy %b want gnt %b v %b d %h busy %b rdy %b",
                 c, gnt, rnd_valid, rnd_data, busy, seed_ready,
                 m_gnt, |m_gnt, m_data, m_busy != 0, m_busy == 0);
      end
      if (m_acc) sv = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) rq[i] = ($urandom % 4 == 0);
        else if (!rq[i]) rq[i] = ($urandom % 3 == 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1;
    seed_valid = 1'b0; seed = 8'h00; req = 4'b0000;
    model_reset();
    test_reset();
    test_single_hold();
    test_back_to_back();
    test_seed(8'hA5, 8'hA9);
    test_seed(8'h00, 8'h40);
    test_seed_vs_req();
    test_reset_mid_warm();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_share_ctrl.md
Name: lfsr_share_ctrl

Overview:
- Controller that owns one 8-bit two-tap Fibonacci LFSR and shares it between NUM_REQ requesters.
- Round-robin arbitration hands out one pseudo-random byte per grant.
- Handles seed loading and a programmable warm-up run before serving resumes.
- Sits between the random-number consumers (scramblers, test-pattern sources) and the LFSR datapath. Consumers never drive the LFSR directly.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TAP_ONE, 2, first feedback tap index (0..7)
TAP_TWO, 4, second feedback tap index (0..7, != TAP_ONE)
WARMUP_CYCLES, 2, LFSR steps run after a seed load before serving (0..255)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
seed_valid  in  1  seed load request
seed  in  8  seed value, sampled when seed_valid & seed_ready
seed_ready  out  1  high only in SERVE state
req  in  NUM_REQ  per-requester random-byte request, level, held until granted
gnt  out  NUM_REQ  one-hot (or zero) grant, registered, one-cycle pulse per grant
rnd_valid  out  1  equals |gnt
rnd_data  out  8  random byte, valid when rnd_valid, else holds last value
busy  out  1  high in LOAD or WARM

Behaviour:
- One clock (clk); reset is asynchronous and active-low (reset_n).
- Reset values: state=SERVE, lfsr=8'h01, rr_ptr=0, gnt=0, rnd_valid=0, rnd_data=8'h00, busy=0, warm_cnt=0.
- LFSR step: next = {lfsr[0]^lfsr[TAP_ONE]^lfsr[TAP_TWO], lfsr[7:1]}. The LFSR advances only on a grant or in WARM, never otherwise.
- FSM states are SERVE, LOAD and WARM.
- SERVE, seed_valid=1:
  - Seed handshake completes; seed takes priority over all req that cycle.
  - No grant that cycle; go to LOAD.
  - lfsr <= (seed==0) ? 8'h01 : seed. Zero seed is forced to avoid lock-up.
- SERVE, seed_valid=0, eligible req nonzero:
  - eligible = req & ~gnt. A requester is ignored in the cycle its registered gnt is high, so a held req is not double-granted.
  - Winner = first eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Next cycle: gnt=onehot(winner), rnd_data=current lfsr, lfsr steps once, rr_ptr=(winner+1) mod NUM_REQ.
- SERVE, no eligible req: gnt=0; lfsr and rr_ptr hold.
- LOAD (1 cycle): if WARMUP_CYCLES==0 go to SERVE, else warm_cnt<=WARMUP_CYCLES-1 and go to WARM.
- WARM: lfsr steps every cycle. At warm_cnt==0 go to SERVE, else decrement warm_cnt.
- In LOAD and WARM: gnt=0, seed_ready=0, req ignored but not lost (requesters keep holding).
- Latency: req asserted in SERVE at cycle t with no contention -> gnt at t+1. Seed accepted at t -> first possible grant at t+2+WARMUP_CYCLES, using the post-warm-up value.
- Max throughput is one grant per cycle across requesters; a single requester holding req continuously is granted every other cycle.
- reset_n asserted mid-LOAD/WARM/grant: all state returns to reset values immediately. Any in-flight seed is discarded.
- seed_valid in LOAD/WARM: not accepted; source must hold it.

Decomposition:
- Shared package lfsr_pkg:
  - state enum (SERVE, LOAD, WARM)
  - LFSR_RESET_VAL=8'h01
  - LFSR_WIDTH=8
- Sub-module lfsr_core:
  - Holds the 8-bit register with parameters TAP_ONE/TAP_TWO.
  - Inputs: step, load, load_val. Output: value.
  - Applies the zero-seed substitution.
- Arbitration and FSM stay in lfsr_share_ctrl.

Test Plan:
- Reset, hold req=4'b0001 -> gnt=0001 every other cycle; rnd_data 8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88.
- Reset, req=4'b1111, each dropped the cycle after its gnt -> gnt 0001, 0010, 0100, 1000 on consecutive cycles; rnd_data 01, 80, 40, 20.
- seed=8'hA5 with WARMUP_CYCLES=2 -> seed_ready low and busy high for 3 cycles; next single grant gives rnd_data=8'hA9.
- seed=8'h00 -> LFSR loads 8'h01; first grant after warm-up matches the reset-sequence value at index WARMUP_CYCLES (8'h40 for default 2).
- seed_valid and req=4'b0010 in the same cycle -> no gnt that cycle; req granted only after WARM; rr_ptr unaffected by the seed.
- reset_n pulsed low during WARM -> gnt=0 and busy=0 immediately; after release the sequence restarts at 8'h01 and rr_ptr=0.
